dmem_wait_ctrl: RTL and testbench

//  Data-memory stage downstream of the ARM core's memory port (ALU result as address, store data, write enable).

---
 rtl/dmem_wait_ctrl_pkg.sv | 28 ++
 rtl/dmem_wait_ctrl_if.sv | 23 ++
 rtl/dmem_wait_ctrl_lane_align.sv | 40 ++++
 rtl/dmem_wait_ctrl.sv | 120 ++++++++++++
 tb/tb_dmem_wait_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/dmem_wait_ctrl_pkg.sv
// Shared definitions for the wait-state data memory: access size codes,
// FSM state encoding and the legality helper used at request acceptance.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } dmemState_e;

    // Size code 2'b11 is handled as a word access.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] byteOff);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = byteOff[0];
            default: bad = (byteOff != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// Core-to-data-memory bus: request/address/data from the core, data and
// handshake status back from the memory stage.
interface dmem_wait_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;

    modport master (
        output mem_req, mem_we, mem_size, addr, wdata,
        input  rdata, stall, done, fault
    );

    modport slave (
        input  mem_req, mem_we, mem_size, addr, wdata,
        output rdata, stall, done, fault
    );
endinterface

// File: rtl/dmem_wait_ctrl_lane_align.sv
// Byte-lane steering: extracts right-aligned, zero-extended load data from a
// stored word and builds per-lane write enables plus a replicated store word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] memWord,
    input  logic [1:0]  byteOff,
    input  logic [1:0]  size,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [3:0]  laneEn,
    output logic [31:0] storeWord
);

    // Lane selection for both directions; replication lets the array write
    // the same word with only the enabled lanes taking effect.
    always_comb begin
        loadData  = memWord;
        laneEn    = 4'b1111;
        storeWord = storeData;
        case (size)
            SZ_BYTE: begin
                loadData  = (memWord >> {byteOff, 3'b000}) & 32'h0000_00FF;
                laneEn    = 4'b0001 << byteOff;
                storeWord = {4{storeData[7:0]}};
            end
            SZ_HALF: begin
                loadData  = byteOff[1] ? {16'h0000, memWord[31:16]} : {16'h0000, memWord[15:0]};
                laneEn    = byteOff[1] ? 4'b1100 : 4'b0011;
                storeWord = {2{storeData[15:0]}};
            end
            default: begin
                loadData  = memWord;
                laneEn    = 4'b1111;
                storeWord = storeData;
            end
        endcase
    end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data memory with a fixed-latency access FSM: stalls the core while an
// access is in flight, supports byte/half/word lanes and flags illegal accesses.
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_wait_ctrl_if.slave   bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dmemState_e        stateR, stateNxt;
    logic [LAT_W-1:0]  cntR;
    logic              weR;
    logic [1:0]        sizeR;
    logic [IDX_W-1:0]  idxR;
    logic [1:0]        offR;
    logic [31:0]       wdataR;
    logic              faultR;
    logic [31:0]       rdataR;
    logic              stallS;
    logic              reqIllegal;
    logic              accept;
    logic [31:0]       loadData;
    logic [3:0]        laneEn;
    logic [31:0]       storeWord;
    logic [31:0]       memArray [DEPTH];

    assign reqIllegal = isMisaligned(bus.mem_size, bus.addr[1:0])
                      || ({2'b00, bus.addr[31:2]} >= 32'(DEPTH));
    assign accept     = (stateR == ST_IDLE) && bus.mem_req;

    dmem_lane_align uAlign (
        .memWord   (memArray[idxR]),
        .byteOff   (offR),
        .size      (sizeR),
        .storeData (wdataR),
        .loadData  (loadData),
        .laneEn    (laneEn),
        .storeWord (storeWord)
    );

    // Next-state and stall; stall rises in the request cycle itself.
    always_comb begin
        stateNxt = stateR;
        stallS   = 1'b0;
        case (stateR)
            ST_IDLE: begin
                if (bus.mem_req) begin
                    stallS   = 1'b1;
                    stateNxt = reqIllegal ? ST_DONE : ST_WAIT;
                end else begin
                    stateNxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stallS   = 1'b1;
                stateNxt = (cntR == {LAT_W{1'b0}}) ? ST_DONE : ST_WAIT;
            end
            ST_DONE: stateNxt = ST_IDLE;
            default: stateNxt = ST_IDLE;
        endcase
    end

    // State, latched request, wait counter and registered load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR <= ST_IDLE;
            cntR   <= {LAT_W{1'b0}};
            rdataR <= 32'h0000_0000;
            faultR <= 1'b0;
            weR    <= 1'b0;
            sizeR  <= SZ_WORD;
            idxR   <= {IDX_W{1'b0}};
            offR   <= 2'b00;
            wdataR <= 32'h0000_0000;
        end else begin
            stateR <= stateNxt;
            if (accept) begin
                weR    <= bus.mem_we;
                sizeR  <= bus.mem_size;
                idxR   <= bus.addr[IDX_W+1:2];
                offR   <= bus.addr[1:0];
                wdataR <= bus.wdata;
                cntR   <= LAT_W'(LATENCY - 1);
                faultR <= reqIllegal;
                if (reqIllegal) begin
                    rdataR <= 32'h0000_0000;
                end
            end else if (stateR == ST_WAIT) begin
                if (cntR != {LAT_W{1'b0}}) begin
                    cntR <= cntR - {{(LAT_W-1){1'b0}}, 1'b1};
                end else begin
                    rdataR <= loadData;
                end
            end
        end
    end

    // Store commit at the end of a clean DONE cycle; array is never reset.
    always_ff @(posedge clk) begin
        if (!rst && stateR == ST_DONE && weR && !faultR) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (laneEn[lane]) begin
                    memArray[idxR][8*lane +: 8] <= storeWord[8*lane +: 8];
                end
            end
        end
    end

    assign bus.stall = stallS;
    assign bus.done  = (stateR == ST_DONE) && !rst;
    assign bus.fault = (stateR == ST_DONE) && !rst && faultR;
    assign bus.rdata = rdataR;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl: one LATENCY=2 instance for most cases
// and a LATENCY=1 instance for back-to-back loads.
module tb_dmem_wait_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    dmem_wait_ctrl_if bus0 ();
    dmem_wait_ctrl_if bus1 ();

    dmem_wait_ctrl #(.DEPTH(64), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_wait_ctrl #(.DEPTH(64), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic we, input logic [1:0] size,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            bus1.mem_req = req; bus1.mem_we = we; bus1.mem_size = size;
            bus1.addr = a; bus1.wdata = wd;
        end else begin
            bus0.mem_req = req; bus0.mem_we = we; bus0.mem_size = size;
            bus0.addr = a; bus0.wdata = wd;
        end
    endtask

    task automatic sample(input bit sel, output logic st, output logic dn, output logic ft,
                          output logic [31:0] rd);
        st = sel ? bus1.stall : bus0.stall;
        dn = sel ? bus1.done  : bus0.done;
        ft = sel ? bus1.fault : bus0.fault;
        rd = sel ? bus1.rdata : bus0.rdata;
    endtask

    // One complete access: counts stall cycles up to done, then checks status and data.
    task automatic access(input bit sel, input logic we, input logic [1:0] size,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic expFault, input logic [31:0] expRd, input string tag);
        int   lat;
        int   stallCyc;
        bit   seen;
        logic st, dn, ft;
        logic [31:0] rd;
        lat = sel ? 1 : 2;
        @(posedge clk); #1;
        drive(sel, 1'b1, we, size, a, wd);
        stallCyc = 0;
        seen     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            sample(sel, st, dn, ft, rd);
            if (dn) begin
                seen = 1'b1;
                break;
            end
            if (st) stallCyc++;
        end
        checkVal({tag, "_done"}, 32'(seen), 32'd1);
        if (seen) begin
            checkVal({tag, "_stallcyc"}, 32'(stallCyc), expFault ? 32'd1 : 32'(lat + 1));
            checkVal({tag, "_fault"}, 32'(ft), 32'(expFault));
            checkVal({tag, "_stallAtDone"}, 32'(st), 32'd0);
            if (!we || expFault) checkVal({tag, "_rdata"}, rd, expRd);
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    endtask

    initial begin
        logic        st, dn, ft;
        logic [31:0] rd;
        bit          anyDone, anyStall, seen;
        int          stallCyc;
        logic [31:0] b2bAddr [3];
        logic [31:0] b2bData [3];

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkVal("rst_rdata", bus0.rdata, 32'h0);
        checkVal("rst_stall", 32'(bus0.stall), 32'd0);
        checkVal("rst_done",  32'(bus0.done),  32'd0);
        checkVal("rst_fault", 32'(bus0.fault), 32'd0);

        // Word store/load round trip.
        access(1'b0, 1'b1, SZ_WORD, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, "t1_st");
        access(1'b0, 1'b0, SZ_WORD, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "t1_ld");

        // Byte and halfword lanes.
        access(1'b0, 1'b1, SZ_WORD, 32'h10, 32'h1122_3344, 1'b0, 32'h0, "t2_init");
        access(1'b0, 1'b1, SZ_BYTE, 32'h13, 32'h0000_00AA, 1'b0, 32'h0, "t2_stb");
        access(1'b0, 1'b0, SZ_WORD, 32'h10, 32'h0, 1'b0, 32'hAA22_3344, "t2_ldw");
        access(1'b0, 1'b0, SZ_BYTE, 32'h12, 32'h0, 1'b0, 32'h0000_0022, "t2_ldb");
        access(1'b0, 1'b0, SZ_HALF, 32'h12, 32'h0, 1'b0, 32'h0000_AA22, "t3_ldh");
        access(1'b0, 1'b1, SZ_HALF, 32'h10, 32'h0000_BEEF, 1'b0, 32'h0, "t3_sth");
        access(1'b0, 1'b0, SZ_WORD, 32'h10, 32'h0, 1'b0, 32'hAA22_BEEF, "t3_ldw");

        // Illegal accesses: misaligned and out of range.
        access(1'b0, 1'b0, SZ_WORD, 32'h11, 32'h0, 1'b1, 32'h0, "t4_misw");
        access(1'b0, 1'b1, SZ_HALF, 32'h13, 32'h0000_5555, 1'b1, 32'h0, "t4_mish");
        access(1'b0, 1'b0, SZ_WORD, 32'h10, 32'h0, 1'b0, 32'hAA22_BEEF, "t4_unchg");
        access(1'b0, 1'b0, SZ_WORD, 32'h100, 32'h0, 1'b1, 32'h0, "t4_oor");

        // Reset during the first WAIT cycle of a store.
        access(1'b0, 1'b1, SZ_WORD, 32'h20, 32'h1234_5678, 1'b0, 32'h0, "t5_init");
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, SZ_WORD, 32'h20, 32'hCAFE_F00D);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        anyDone  = 1'b0;
        anyStall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            anyDone  = anyDone  | bus0.done;
            anyStall = anyStall | bus0.stall;
        end
        checkVal("t5_noDone",  32'(anyDone),  32'd0);
        checkVal("t5_noStall", 32'(anyStall), 32'd0);
        access(1'b0, 1'b0, SZ_WORD, 32'h20, 32'h0, 1'b0, 32'h1234_5678, "t5_unchg");

        // Back-to-back loads with LATENCY=1 and mem_req held high.
        access(1'b1, 1'b1, SZ_WORD, 32'h0, 32'h0102_0304, 1'b0, 32'h0, "t6_st0");
        access(1'b1, 1'b1, SZ_WORD, 32'h4, 32'hA5A5_5A5A, 1'b0, 32'h0, "t6_st1");
        b2bAddr[0] = 32'h0; b2bData[0] = 32'h0102_0304;
        b2bAddr[1] = 32'h4; b2bData[1] = 32'hA5A5_5A5A;
        b2bAddr[2] = 32'h0; b2bData[2] = 32'h0102_0304;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, SZ_WORD, b2bAddr[0], 32'h0);
        for (int k = 0; k < 3; k++) begin
            stallCyc = 0;
            seen     = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                sample(1'b1, st, dn, ft, rd);
                if (dn) begin
                    seen = 1'b1;
                    break;
                end
                if (st) stallCyc++;
            end
            checkVal($sformatf("t6_b2b%0d_done", k), 32'(seen), 32'd1);
            checkVal($sformatf("t6_b2b%0d_stallcyc", k), 32'(stallCyc), 32'd2);
            checkVal($sformatf("t6_b2b%0d_rdata", k), rd, b2bData[k]);
            @(posedge clk); #1;
            if (k < 2) drive(1'b1, 1'b1, 1'b0, SZ_WORD, b2bAddr[k+1], 32'h0);
            else       drive(1'b1, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
